// File: rtl/bsg_abs_accum_pkg.sv
// bsg_abs_accum_pkg: shared types for the frame magnitude accumulator.
package bsg_abs_accum_pkg;
    typedef enum logic {eAccum, eDone} state_e;
endpackage

// File: rtl/bsg_abs.sv
// bsg_abs: two's-complement magnitude read back as unsigned; the most negative value maps to 2^(width_p-1).
module bsg_abs #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0] a_i,
    output logic [width_p-1:0] o
);
    assign o = a_i[width_p-1] ? (width_p'(0) - a_i) : a_i;
endmodule

// File: rtl/bsg_abs_accum.sv
// bsg_abs_accum: per-frame sum and peak of sample magnitudes, one result per els_p samples.
module bsg_abs_accum
    import bsg_abs_accum_pkg::*;
#(
    parameter  int width_p      = 16,
    parameter  int els_p        = 64,
    localparam int sum_width_lp = width_p + $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [sum_width_lp-1:0] sum_o,
    output logic [width_p-1:0]      max_o,
    input  logic                    yumi_i
);
    localparam int cnt_width_lp = $clog2(els_p);

    state_e                  state_q, state_d;
    logic [sum_width_lp-1:0] sum_q, sum_d;
    logic [width_p-1:0]      max_q, max_d, mag;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    ready_q, ready_d;
    logic                    accept, last, take;

    bsg_abs #(.width_p(width_p)) abs_inst (.a_i(data_i), .o(mag));

    assign accept = v_i & ready_q;
    assign last   = count_q == cnt_width_lp'(els_p - 1);
    assign take   = (state_q == eDone) & yumi_i;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        max_d   = max_q;
        count_d = count_q;
        if (take) begin
            state_d = eAccum;
            sum_d   = '0;
            max_d   = '0;
            count_d = '0;
        end else if (accept) begin
            state_d = last ? eDone : eAccum;
            sum_d   = sum_q + sum_width_lp'(mag);
            max_d   = (mag > max_q) ? mag : max_q;
            count_d = last ? '0 : count_q + 1'b1;
        end
        ready_d = state_d == eAccum;
    end

    // ready is its own flop so it stays low through reset and has no path from v_i/yumi_i.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eAccum;
            sum_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign v_o     = state_q == eDone;
    assign sum_o   = sum_q;
    assign max_o   = max_q;
endmodule

// File: tb/tb_bsg_abs_accum.sv
// tb_bsg_abs_accum: directed scenarios for bsg_abs_accum with width_p=16, els_p=4.
module tb_bsg_abs_accum;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0;
    logic        yumi_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        ready_o, v_o;
    logic [17:0] sum_o;
    logic [15:0] max_o;
    int          n_cmp = 0;
    int          n_bad = 0;

    bsg_abs_accum #(.width_p(16), .els_p(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .sum_o(sum_o), .max_o(max_o), .yumi_i(yumi_i)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic [15:0] d, input logic y);
        v_i = v;
        data_i = d;
        yumi_i = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (v_o !== 1'b0 || ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: v_o=%b ready_o=%b want 0 0", v_o, ready_o);
        end
        n_cmp++;
        if (sum_o !== 18'd0 || max_o !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_data: sum=%0d max=%0d want 0 0", sum_o, max_o);
        end
        reset_i = 1'b0;
        cyc(1'b0, 16'd0, 1'b0);
        n_cmp++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: ready_o=%b v_o=%b want 1 0", ready_o, v_o);
        end
    endtask

    task automatic test_basic();
        cyc(1'b1, 16'd3, 1'b0);
        cyc(1'b1, -16'sd5, 1'b0);
        cyc(1'b1, 16'h8000, 1'b0);
        n_cmp++;
        if (v_o !== 1'b0 || ready_o !== 1'b1 || sum_o !== 18'd32776) begin
            n_bad++;
            $display("FAIL basic_partial: v_o=%b ready_o=%b sum=%0d want 0 1 32776", v_o, ready_o, sum_o);
        end
        cyc(1'b1, 16'd7, 1'b0);
        n_cmp++;
        if (v_o !== 1'b1 || ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done: v_o=%b ready_o=%b want 1 0", v_o, ready_o);
        end
        n_cmp++;
        if (sum_o !== 18'd32783 || max_o !== 16'd32768) begin
            n_bad++;
            $display("FAIL basic_result: sum=%0d max=%0d want 32783 32768", sum_o, max_o);
        end
        cyc(1'b0, 16'd0, 1'b1);
        n_cmp++;
        if (v_o !== 1'b0 || ready_o !== 1'b1 || sum_o !== 18'd0 || max_o !== 16'd0) begin
            n_bad++;
            $display("FAIL basic_consume: v_o=%b ready_o=%b sum=%0d max=%0d want 0 1 0 0", v_o, ready_o, sum_o, max_o);
        end
    endtask

    task automatic test_hold();
        repeat (4) cyc(1'b1, 16'h7FFF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (v_o !== 1'b1 || ready_o !== 1'b0 || sum_o !== 18'd131068 || max_o !== 16'd32767) begin
                n_bad++;
                $display("FAIL hold_%0d: v_o=%b ready_o=%b sum=%0d max=%0d want 1 0 131068 32767", i, v_o, ready_o, sum_o, max_o);
            end
            cyc(1'b0, 16'd0, 1'b0);
        end
        cyc(1'b0, 16'd0, 1'b1);
        n_cmp++;
        if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_consume: v_o=%b ready_o=%b want 0 1", v_o, ready_o);
        end
    endtask

    task automatic test_gaps();
        logic [6:0] vp;
        logic [15:0] smp [4];
        int k;
        vp = 7'b1011001;
        smp[0] = -16'sd1;
        smp[1] = -16'sd2;
        smp[2] = -16'sd3;
        smp[3] = -16'sd4;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (vp[6-i]) begin
                cyc(1'b1, smp[k], 1'b0);
                k++;
            end else begin
                cyc(1'b0, 16'h7000, 1'b0);
            end
            if (i == 5) begin
                n_cmp++;
                if (v_o !== 1'b0 || sum_o !== 18'd6) begin
                    n_bad++;
                    $display("FAIL gaps_partial: v_o=%b sum=%0d want 0 6", v_o, sum_o);
                end
            end
        end
        n_cmp++;
        if (v_o !== 1'b1 || sum_o !== 18'd10 || max_o !== 16'd4) begin
            n_bad++;
            $display("FAIL gaps_result: v_o=%b sum=%0d max=%0d want 1 10 4", v_o, sum_o, max_o);
        end
        cyc(1'b0, 16'd0, 1'b1);
    endtask

    task automatic test_yumi_same_cycle();
        repeat (4) cyc(1'b1, 16'd2, 1'b0);
        n_cmp++;
        if (v_o !== 1'b1 || sum_o !== 18'd8) begin
            n_bad++;
            $display("FAIL yumi_setup: v_o=%b sum=%0d want 1 8", v_o, sum_o);
        end
        cyc(1'b1, 16'd9, 1'b1);
        n_cmp++;
        if (v_o !== 1'b0 || ready_o !== 1'b1 || sum_o !== 18'd0) begin
            n_bad++;
            $display("FAIL yumi_ignore: v_o=%b ready_o=%b sum=%0d want 0 1 0", v_o, ready_o, sum_o);
        end
        repeat (4) cyc(1'b1, 16'd1, 1'b0);
        n_cmp++;
        if (v_o !== 1'b1 || sum_o !== 18'd4 || max_o !== 16'd1) begin
            n_bad++;
            $display("FAIL yumi_next: v_o=%b sum=%0d max=%0d want 1 4 1", v_o, sum_o, max_o);
        end
        cyc(1'b0, 16'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 16'd100, 1'b0);
        cyc(1'b1, -16'sd100, 1'b0);
        n_cmp++;
        if (sum_o !== 18'd200 || max_o !== 16'd100) begin
            n_bad++;
            $display("FAIL rmid_partial: sum=%0d max=%0d want 200 100", sum_o, max_o);
        end
        v_i = 1'b0;
        reset_i = 1'b1;
        #1;
        n_cmp++;
        if (v_o !== 1'b0 || ready_o !== 1'b0 || sum_o !== 18'd0 || max_o !== 16'd0) begin
            n_bad++;
            $display("FAIL rmid_async: v_o=%b ready_o=%b sum=%0d max=%0d want 0 0 0 0", v_o, ready_o, sum_o, max_o);
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        cyc(1'b0, 16'd0, 1'b0);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b0);
        n_cmp++;
        if (v_o !== 1'b1 || sum_o !== 18'd10 || max_o !== 16'd4) begin
            n_bad++;
            $display("FAIL rmid_result: v_o=%b sum=%0d max=%0d want 1 10 4", v_o, sum_o, max_o);
        end
        cyc(1'b0, 16'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int k;
        int f;
        logic exp_v;
        k = 1;
        for (int t = 1; t <= 15; t++) begin
            if (t % 5 != 0) begin
                cyc(1'b1, 16'(k), 1'b0);
                k++;
            end else begin
                cyc(1'b1, 16'd100, 1'b1);
            end
            exp_v = (t % 5 == 4);
            f = t / 5;
            n_cmp++;
            if (v_o !== exp_v || ready_o !== !exp_v) begin
                n_bad++;
                $display("FAIL b2b_flags_t%0d: v_o=%b ready_o=%b want %b %b", t, v_o, ready_o, exp_v, !exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (sum_o !== 18'(16 * f + 10) || max_o !== 16'(4 * f + 4)) begin
                    n_bad++;
                    $display("FAIL b2b_frame%0d: sum=%0d max=%0d want %0d %0d", f, sum_o, max_o, 16 * f + 10, 4 * f + 4);
                end
            end
        end
        cyc(1'b0, 16'd0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_gaps();
        test_yumi_same_cycle();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
